// File: rtl/line_buf_3row.sv
// line_buf_3row: three-row line buffer producing vertically aligned taps.
// Optional LB_ZERO_FILL_EN: also emit zero-padded taps in rows 0 and 1.
module line_buf_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 320,
    parameter int PIC_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             sof,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             valid_out,
    output logic             frame_done
);

    localparam int AW = (PIC_WIDTH > 2) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [8:0] COL_LAST = 9'(PIC_WIDTH - 1);
    localparam logic [9:0] ROW_LAST = 10'(PIC_HEIGHT - 1);

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [8:0]       col_q;
    logic [8:0]       col_d;
    logic [9:0]       row_q;
    logic [9:0]       row_d;

    logic [WIDTH-1:0] dout1_q;
    logic [WIDTH-1:0] dout1_d;
    logic [WIDTH-1:0] dout2_q;
    logic [WIDTH-1:0] dout2_d;
    logic [WIDTH-1:0] dout3_q;
    logic [WIDTH-1:0] dout3_d;
    logic             valid_q;
    logic             valid_d;
    logic             done_q;
    logic             done_d;

    // Row r-1 and row r-2 storage; never cleared, stale rows are masked.
    logic [WIDTH-1:0] ram_a [PIC_WIDTH];
    logic [WIDTH-1:0] ram_b [PIC_WIDTH];

    logic             sof_acc;
    state_t           st_eff;
    logic [8:0]       col_eff;
    logic [9:0]       row_eff;
    logic             col_wrap;
    logic             row_wrap;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Effective raster position: an accepted sof restarts at row 0, col 0.
    always_comb begin
        sof_acc  = valid_in & sof;
        col_eff  = sof_acc ? 9'd0 : col_q;
        row_eff  = sof_acc ? 10'd0 : row_q;
        st_eff   = sof_acc ? ROW0 : state_q;
        col_wrap = (col_eff == COL_LAST);
        row_wrap = (row_eff == ROW_LAST);
        addr     = col_eff[AW-1:0];
        rd_a     = ram_a[addr];
        rd_b     = ram_b[addr];
    end

    // Counter and fill-state advance for each accepted pixel.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (valid_in) begin
            state_d = st_eff;
            row_d   = row_eff;
            col_d   = col_wrap ? 9'd0 : col_eff + 9'd1;
            if (col_wrap) begin
                row_d = row_wrap ? 10'd0 : row_eff + 10'd1;
                unique case (st_eff)
                    ROW0:    state_d = ROW1;
                    ROW1:    state_d = RUN;
                    RUN:     state_d = row_wrap ? ROW0 : RUN;
                    default: state_d = ROW0;
                endcase
            end
        end
    end

    // Tap, strobe and end-of-frame values for the next cycle.
    always_comb begin
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        dout3_d = dout3_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (valid_in) begin
            dout1_d = rd_b;
            dout2_d = rd_a;
            dout3_d = din;
            done_d  = col_wrap & row_wrap;
`ifdef LB_ZERO_FILL_EN
            valid_d = 1'b1;
            if (st_eff != RUN) begin
                dout1_d = '0;
            end
            if (st_eff == ROW0) begin
                dout2_d = '0;
            end
`else
            valid_d = (st_eff == RUN);
`endif
        end
    end

    // Read-first row shift: current pixel into ram_a, old ram_a into ram_b.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            ram_a[addr] <= din;
            ram_b[addr] <= rd_a;
        end
    end

    // Control state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ROW0;
            col_q   <= 9'd0;
            row_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout1_q <= '0;
            dout2_q <= '0;
            dout3_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            dout3_q <= dout3_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign dout1      = dout1_q;
    assign dout2      = dout2_q;
    assign dout3      = dout3_q;
    assign valid_out  = valid_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_line_buf_3row.sv
// tb_line_buf_3row: directed frames on a 4x4 picture, image-level model.
// Default build and LB_ZERO_FILL_EN build are both covered by the model.
module tb_line_buf_3row;

    localparam int W = 4;
    localparam int H = 4;
    localparam int DW = 8;
`ifdef LB_ZERO_FILL_EN
    localparam int NV  = 16;
    localparam int OFS = 8;
`else
    localparam int NV  = 8;
    localparam int OFS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic          sof = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic [DW-1:0] dout3;
    logic          valid_out;
    logic          frame_done;

    line_buf_3row #(
        .WIDTH(DW),
        .PIC_WIDTH(W),
        .PIC_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_in(valid_in),
        .sof(sof),
        .din(din),
        .dout1(dout1),
        .dout2(dout2),
        .dout3(dout3),
        .valid_out(valid_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Image model: position in the picture plus the pixels seen so far.
    int            r_m = 0;
    int            c_m = 0;
    logic [DW-1:0] img [H][W];
    logic          e_v = 1'b0;
    logic          e_fd = 1'b0;
    logic          e_known = 1'b1;
    logic [DW-1:0] e_d1 = '0;
    logic [DW-1:0] e_d2 = '0;
    logic [DW-1:0] e_d3 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m = 0; c_m = 0;
            e_v = 0; e_fd = 0; e_known = 1;
            e_d1 = '0; e_d2 = '0; e_d3 = '0;
        end else if (valid_in) begin
            if (sof) begin
                r_m = 0; c_m = 0;
            end
            img[r_m][c_m] = din;
            e_fd = (r_m == H - 1) && (c_m == W - 1);
            if (r_m >= 2) begin
                e_v = 1; e_known = 1;
                e_d1 = img[r_m-2][c_m];
                e_d2 = img[r_m-1][c_m];
                e_d3 = din;
            end else begin
`ifdef LB_ZERO_FILL_EN
                e_v = 1; e_known = 1;
                e_d1 = '0;
                e_d2 = (r_m == 1) ? img[0][c_m] : '0;
                e_d3 = din;
`else
                e_v = 0; e_known = 0;
`endif
            end
            c_m++;
            if (c_m == W) begin
                c_m = 0;
                r_m = (r_m + 1) % H;
            end
        end else begin
            e_v = 0;
            e_fd = 0;
        end
    end

    logic [23:0] q_out[$];
    logic [23:0] q_ref[$];
    int          fdcnt = 0;
    int          fd_total = 0;
    logic [DW-1:0] fd_d3 = '0;

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_out", 32'(valid_out), 32'(e_v));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            if (e_known) begin
                chk("dout1", 32'(dout1), 32'(e_d1));
                chk("dout2", 32'(dout2), 32'(e_d2));
                chk("dout3", 32'(dout3), 32'(e_d3));
            end
            if (valid_out) q_out.push_back({dout1, dout2, dout3});
            if (frame_done) begin
                fdcnt++;
                fd_total++;
                fd_d3 = dout3;
            end
        end
    end

    function automatic logic [23:0] get(input int i);
        if (i < q_out.size()) return q_out[i];
        return 24'hxxxxxx;
    endfunction

    task automatic pix(input logic s, input logic [DW-1:0] d);
        @(posedge clk); #1;
        valid_in = 1'b1; sof = s; din = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            valid_in = 1'b0; sof = 1'b0;
        end
    endtask

    // Stream npix raster pixels; tallies restart once the first is driven.
    task automatic frame(input int base, input bit gap, input bit s,
                         input int npix);
        for (int i = 0; i < npix; i++) begin
            pix(s && (i == 0), DW'(base + (i / W) * 16 + (i % W)));
            if (i == 0) begin
                @(negedge clk); #1;
                fdcnt = 0;
                q_out.delete();
            end
            if (gap) idle(1);
        end
    endtask

    int fd_before;

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout1", 32'(dout1), 32'h0);
        chk("rst_dout2", 32'(dout2), 32'h0);
        chk("rst_dout3", 32'(dout3), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_fdone", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame A.
        frame(0, 1'b0, 1'b1, 16);
        idle(2);
        chk("A_count", 32'(q_out.size()), 32'(NV));
`ifdef LB_ZERO_FILL_EN
        chk("A_first", 32'(get(0)), 32'h000000);
        chk("A_px11", 32'(get(5)), 32'h000111);
`else
        chk("A_first", 32'(get(0)), 32'h001020);
`endif
        chk("A_last", 32'(get(NV - 1)), 32'h132333);
        chk("A_fdcnt", 32'(fdcnt), 32'd1);
        chk("A_fd_px", 32'(fd_d3), 32'h33);
        q_ref = q_out;

        // Back-to-back frames; the second carries distinct data.
        frame(0, 1'b0, 1'b1, 16);
        frame(8'h40, 1'b0, 1'b1, 16);
        idle(2);
        chk("B_count", 32'(q_out.size()), 32'(NV));
        chk("B_first", 32'(get(OFS)), 32'h405060);
        chk("B_last", 32'(get(NV - 1)), 32'h536373);
        chk("B_fdcnt", 32'(fdcnt), 32'd1);
        chk("B_fd_px", 32'(fd_d3), 32'h73);

        // Same frame as A with a gap after every pixel.
        frame(0, 1'b1, 1'b1, 16);
        idle(2);
        chk("G_count", 32'(q_out.size()), 32'(q_ref.size()));
        for (int i = 0; i < q_ref.size(); i++)
            chk("G_tap", 32'(get(i)), 32'(q_ref[i]));
        chk("G_fdcnt", 32'(fdcnt), 32'd1);

        // Restart at row 3, column 1 of a frame.
        frame(0, 1'b0, 1'b1, 13);
        fd_before = fd_total;
        frame(8'h80, 1'b0, 1'b1, 16);
        idle(2);
        chk("S_fdtotal", 32'(fd_total), 32'(fd_before + 1));
        chk("S_count", 32'(q_out.size()), 32'(NV));
        chk("S_first", 32'(get(OFS)), 32'h8090a0);
        chk("S_fdcnt", 32'(fdcnt), 32'd1);

        // Reset pulse at row 2, column 2; restart without sof.
        frame(0, 1'b0, 1'b0, 10);
        @(posedge clk); #1;
        chk("R_pre_valid", 32'(valid_out), 32'h1);
        valid_in = 1'b0; sof = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("R_dout1", 32'(dout1), 32'h0);
        chk("R_dout2", 32'(dout2), 32'h0);
        chk("R_dout3", 32'(dout3), 32'h0);
        chk("R_valid", 32'(valid_out), 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame(8'hc0, 1'b0, 1'b0, 16);
        idle(2);
        chk("R_count", 32'(q_out.size()), 32'(NV));
        chk("R_first", 32'(get(OFS)), 32'hc0d0e0);
        chk("R_fdcnt", 32'(fdcnt), 32'd1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
